// File: rtl/serial_router_pkg.sv
// Shared types and defaults for the serial port router.
package serial_router_pkg;

    localparam int unsigned STATE_W    = 2;
    localparam int unsigned DEF_CNT_W  = 8;
    localparam int unsigned DEF_PORT_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        ROUTE  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter for remaining payload bits; saturates at zero.
module bit_down_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] rem,
    output logic             last,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem <= '0;
        end else if (load) begin
            rem <= load_val;
        end else if (dec && (rem != '0)) begin
            rem <= rem - 1'b1;
        end
    end

    assign last = (rem == CNT_W'(1));
    assign zero = (rem == '0);

endmodule

// File: rtl/serial_port_router.sv
// Routes an nt-bit serial payload to the port latched with ntValid, then pulses done.
// Define PARITY_CHECK_EN to consume and check a trailing even-parity bit.
module serial_port_router
    import serial_router_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned PORT_W    = DEF_PORT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serIn,
    input  logic [PORT_W-1:0]    portSel,
    input  logic                 ntValid,
    input  logic [CNT_W-1:0]     nt,
    output logic [NUM_PORTS-1:0] serOut,
    output logic [NUM_PORTS-1:0] serOutValid,
    output logic                 busy,
    output logic                 done,
    output logic                 parityErr
);

    state_t                 state;
    logic [PORT_W-1:0]      port;
    logic [NUM_PORTS-1:0]   sel_mask;
    logic [CNT_W-1:0]       rem;
    logic                   cnt_load;
    logic                   cnt_dec;
    logic                   cnt_last;
    logic                   cnt_zero;

    assign cnt_load = (state == IDLE) && ntValid;
    assign cnt_dec  = (state == ROUTE);

    bit_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (nt),
        .dec      (cnt_dec),
        .rem      (rem),
        .last     (cnt_last),
        .zero     (cnt_zero)
    );

    // An out-of-range port matches no bit, so the payload is consumed silently.
    always_comb begin
        sel_mask = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            sel_mask[i] = (PORT_W'(i) == port);
        end
    end

`ifdef PARITY_CHECK_EN
    logic par_acc;
    localparam state_t AFTER_PAYLOAD = PARITY;
`else
    localparam state_t AFTER_PAYLOAD = DONE;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            port        <= '0;
            serOut      <= '0;
            serOutValid <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            parityErr   <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_acc     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    serOut      <= '0;
                    serOutValid <= '0;
                    done        <= 1'b0;
                    parityErr   <= 1'b0;
`ifdef PARITY_CHECK_EN
                    par_acc     <= 1'b0;
`endif
                    if (ntValid) begin
                        port  <= portSel;
                        busy  <= 1'b1;
                        state <= (nt != '0) ? ROUTE : AFTER_PAYLOAD;
                    end
                end
                ROUTE: begin
                    serOut      <= serIn ? sel_mask : '0;
                    serOutValid <= sel_mask;
`ifdef PARITY_CHECK_EN
                    par_acc     <= par_acc ^ serIn;
`endif
                    if (cnt_last || cnt_zero) begin
                        state <= AFTER_PAYLOAD;
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    serOut      <= '0;
                    serOutValid <= '0;
                    par_acc     <= par_acc ^ serIn;
                    state       <= DONE;
                end
`endif
                DONE: begin
                    serOut      <= '0;
                    serOutValid <= '0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
`ifdef PARITY_CHECK_EN
                    parityErr   <= par_acc;
`endif
                    state       <= IDLE;
                end
                default: begin
                    serOut      <= '0;
                    serOutValid <= '0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
